stage_if: RTL and testbench

- Instruction-fetch stage of the turbo RV32 pipeline. It sits directly upstream of the decode stage.
- Owns the fetch PC and runs a single-outstanding request/response handshake with instruction memory.
- Presents the fetched word plus its PC to decode with a Done flag, and holds it under decode back-pressure.
- Redirects to the target PC computed by decode when a taken-branch feedback arrives, squashing any in-flight fetch.

---
 rtl/stage_if.sv | 113 +++++++++++
 tb/tb_stage_if.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the fetch PC and runs a single-outstanding
// request/response handshake with instruction memory, feeding decode.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  output logic [31:0] Inst,
  output logic [31:0] PC_O,
  output logic        Done_O,
  input  logic [31:0] next_PC,
  input  logic        Feedback_Branch,
  input  logic        Feedback_Mem_Acc
);

  typedef enum logic [2:0] {
    s_INIT = 3'b001,
    s_IF   = 3'b010,
    s_IW   = 3'b100
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_inst, w_inst_next;
  logic [31:0] r_pc_o, w_pc_o_next;
  logic        r_done, w_done_next;
  logic        r_squash, w_squash_next;

  logic        w_slot_free;
  logic        w_consume;
  logic        w_fire;
  logic        w_accept;
  logic [31:0] w_redirect;

  assign w_redirect  = next_PC & ~32'h0000_0003;
  assign w_slot_free = !r_done || !Feedback_Mem_Acc;
  assign w_consume   = r_done && !Feedback_Mem_Acc;

  assign Inst_Req_Valid = (r_state == s_IF);
  assign Inst_Ready     = (r_state == s_IW) && (r_squash || w_slot_free);
  assign w_fire         = Inst_Req_Valid && Inst_Req_Ready;
  assign w_accept       = Inst_Valid && Inst_Ready;

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_inst_next   = r_inst;
    w_pc_o_next   = r_pc_o;
    w_done_next   = r_done && !w_consume;
    w_squash_next = r_squash;

    case (r_state)
      s_INIT: w_state_next = s_IF;
      s_IF: begin
        if (w_fire) begin
          w_state_next  = s_IW;
          w_squash_next = Feedback_Branch;
        end
      end
      s_IW: begin
        if (w_accept) begin
          w_state_next  = s_IF;
          w_squash_next = 1'b0;
          // A response is kept only if it is neither stale nor overtaken by a redirect.
          if (!r_squash && !Feedback_Branch) begin
            w_inst_next = Instruction;
            w_pc_o_next = r_pc;
            w_done_next = 1'b1;
            w_pc_next   = r_pc + 32'd4;
          end
        end else if (Feedback_Branch) begin
          w_squash_next = 1'b1;
        end
      end
      default: w_state_next = s_INIT;
    endcase

    if (Feedback_Branch) begin
      w_done_next = 1'b0;
      w_pc_next   = w_redirect;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= s_INIT;
      r_pc     <= RESET_PC;
      r_inst   <= 32'h0000_0013;
      r_pc_o   <= 32'h0000_0000;
      r_done   <= 1'b0;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_inst   <= w_inst_next;
      r_pc_o   <= w_pc_o_next;
      r_done   <= w_done_next;
      r_squash <= w_squash_next;
    end
  end

  assign PC     = r_pc;
  assign Inst   = r_inst;
  assign PC_O   = r_pc_o;
  assign Done_O = r_done;

endmodule

// File: tb/tb_stage_if.sv
// Directed cycle-trace bench for stage_if with a small instruction-memory model.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready = 1'b0;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Inst;
  logic [31:0] PC_O;
  logic        Done_O;
  logic [31:0] next_PC = 32'h0;
  logic        Feedback_Branch = 1'b0;
  logic        Feedback_Mem_Acc = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_delay = 1;

  always #5 clk = ~clk;

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PC(PC),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Inst(Inst), .PC_O(PC_O), .Done_O(Done_O), .next_PC(next_PC),
    .Feedback_Branch(Feedback_Branch), .Feedback_Mem_Acc(Feedback_Mem_Acc)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: word_at = 32'h0010_0093;
      32'h0000_0004: word_at = 32'h0020_0113;
      default:       word_at = 32'hA500_0000 ^ a;
    endcase
  endfunction

  // Memory: one response per accepted request, resp_delay cycles after the fire edge.
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      Inst_Valid  <= 1'b0;
      Instruction <= 32'h0;
      mem_pend    <= 1'b0;
      mem_cnt     <= 0;
      mem_addr    <= 32'h0;
    end else begin
      if (Inst_Valid && Inst_Ready) Inst_Valid <= 1'b0;
      if (Inst_Req_Valid && Inst_Req_Ready) begin
        if (resp_delay <= 1) begin
          Inst_Valid  <= 1'b1;
          Instruction <= word_at(PC);
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= resp_delay - 2;
          mem_addr <= PC;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 0) begin
          Inst_Valid  <= 1'b1;
          Instruction <= word_at(mem_addr);
          mem_pend    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  typedef struct {
    logic        rdy, macc, br;
    logic [31:0] npc;
    int          dly;
    logic [31:0] pc;
    logic        rv, ir, done;
    logic [31:0] pco, inst;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rdy, input logic macc, input logic br,
                              input logic [31:0] npc, input int dly,
                              input logic [31:0] pc, input logic rv, input logic ir,
                              input logic done, input logic [31:0] pco,
                              input logic [31:0] inst);
    vec_t v;
    v.rdy = rdy; v.macc = macc; v.br = br; v.npc = npc; v.dly = dly;
    v.pc = pc; v.rv = rv; v.ir = ir; v.done = done; v.pco = pco; v.inst = inst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    bit seen;

    //              rdy mac br npc           dly  PC            rv ir dn PC_O          Inst
    vecs[0]  = mk(1, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0013);
    vecs[1]  = mk(1, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,        32'h0000_0013);
    vecs[2]  = mk(1, 0, 0, 32'h0,        1, 32'h0,        0, 1, 0, 32'h0,        32'h0000_0013);
    vecs[3]  = mk(1, 0, 0, 32'h0,        1, 32'h4,        1, 0, 1, 32'h0,        32'h0010_0093);
    vecs[4]  = mk(1, 0, 0, 32'h0,        1, 32'h4,        0, 1, 0, 32'h0,        32'h0010_0093);
    vecs[5]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        1, 0, 1, 32'h4,        32'h0020_0113);
    vecs[6]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        0, 1, 0, 32'h4,        32'h0020_0113);
    vecs[7]  = mk(1, 0, 0, 32'h0,        1, 32'hC,        1, 0, 1, 32'h8,        32'hA500_0008);
    vecs[8]  = mk(1, 0, 0, 32'h0,        1, 32'hC,        0, 1, 0, 32'h8,        32'hA500_0008);
    vecs[9]  = mk(1, 0, 0, 32'h0,        1, 32'h10,       1, 0, 1, 32'hC,        32'hA500_000C);
    vecs[10] = mk(1, 0, 0, 32'h0,        1, 32'h10,       0, 1, 0, 32'hC,        32'hA500_000C);
    vecs[11] = mk(1, 1, 0, 32'h0,        1, 32'h14,       1, 0, 1, 32'h10,       32'hA500_0010);
    vecs[12] = mk(1, 1, 0, 32'h0,        1, 32'h14,       0, 0, 1, 32'h10,       32'hA500_0010);
    vecs[13] = mk(1, 1, 0, 32'h0,        1, 32'h14,       0, 0, 1, 32'h10,       32'hA500_0010);
    vecs[14] = mk(1, 1, 0, 32'h0,        1, 32'h14,       0, 0, 1, 32'h10,       32'hA500_0010);
    vecs[15] = mk(1, 1, 0, 32'h0,        1, 32'h14,       0, 0, 1, 32'h10,       32'hA500_0010);
    vecs[16] = mk(1, 0, 0, 32'h0,        1, 32'h14,       0, 1, 1, 32'h10,       32'hA500_0010);
    vecs[17] = mk(1, 0, 0, 32'h0,        3, 32'h18,       1, 0, 1, 32'h14,       32'hA500_0014);
    vecs[18] = mk(1, 0, 1, 32'h200,      3, 32'h18,       0, 1, 0, 32'h14,       32'hA500_0014);
    vecs[19] = mk(1, 0, 0, 32'h0,        3, 32'h200,      0, 1, 0, 32'h14,       32'hA500_0014);
    vecs[20] = mk(1, 0, 0, 32'h0,        3, 32'h200,      0, 1, 0, 32'h14,       32'hA500_0014);
    vecs[21] = mk(1, 0, 0, 32'h0,        1, 32'h200,      1, 0, 0, 32'h14,       32'hA500_0014);
    vecs[22] = mk(1, 0, 0, 32'h0,        1, 32'h200,      0, 1, 0, 32'h14,       32'hA500_0014);
    vecs[23] = mk(0, 0, 1, 32'h80,       1, 32'h204,      1, 0, 1, 32'h200,      32'hA500_0200);
    vecs[24] = mk(1, 0, 0, 32'h0,        1, 32'h80,       1, 0, 0, 32'h200,      32'hA500_0200);
    vecs[25] = mk(1, 0, 0, 32'h0,        1, 32'h80,       0, 1, 0, 32'h200,      32'hA500_0200);
    vecs[26] = mk(1, 0, 0, 32'h0,        1, 32'h84,       1, 0, 1, 32'h80,       32'hA500_0080);
    vecs[27] = mk(1, 0, 1, 32'h103,      1, 32'h84,       0, 1, 0, 32'h80,       32'hA500_0080);
    vecs[28] = mk(1, 0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h80,       32'hA500_0080);
    vecs[29] = mk(1, 0, 0, 32'h0,        1, 32'h100,      0, 1, 0, 32'h80,       32'hA500_0080);
    vecs[30] = mk(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h104,     1, 0, 1, 32'h100,      32'hA500_0100);
    vecs[31] = mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 1, 0, 32'h100,     32'hA500_0100);
    vecs[32] = mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 0, 0, 32'h100,     32'hA500_0100);
    vecs[33] = mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 1, 0, 32'h100,     32'hA500_0100);
    vecs[34] = mk(0, 0, 1, 32'h40,       1, 32'h0,        1, 0, 1, 32'hFFFF_FFFC, 32'h5AFF_FFFC);
    vecs[35] = mk(1, 0, 0, 32'h0,        3, 32'h40,       1, 0, 0, 32'hFFFF_FFFC, 32'h5AFF_FFFC);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      Inst_Req_Ready   = vecs[i].rdy;
      Feedback_Mem_Acc = vecs[i].macc;
      Feedback_Branch  = vecs[i].br;
      next_PC          = vecs[i].npc;
      resp_delay       = vecs[i].dly;
      #1;
      chk($sformatf("v%0d_PC", i),         PC,                     vecs[i].pc);
      chk($sformatf("v%0d_ReqValid", i),   {31'h0, Inst_Req_Valid}, {31'h0, vecs[i].rv});
      chk($sformatf("v%0d_InstReady", i),  {31'h0, Inst_Ready},     {31'h0, vecs[i].ir});
      chk($sformatf("v%0d_Done", i),       {31'h0, Done_O},         {31'h0, vecs[i].done});
      chk($sformatf("v%0d_PC_O", i),       PC_O,                   vecs[i].pco);
      chk($sformatf("v%0d_Inst", i),       Inst,                   vecs[i].inst);
      $display("vec %0d: PC=%08h req=%0b rdy=%0b done=%0b PC_O=%08h Inst=%08h",
               i, PC, Inst_Req_Valid, Inst_Ready, Done_O, PC_O, Inst);
      @(negedge clk);
    end

    // Asynchronous reset while waiting for a delayed response at 0x40.
    Inst_Req_Ready   = 1'b1;
    Feedback_Branch  = 1'b0;
    Feedback_Mem_Acc = 1'b0;
    #2;
    chk("pre_rst_InstReady", {31'h0, Inst_Ready}, 32'h1);
    chk("pre_rst_PC", PC, 32'h40);
    rst = 1'b1;
    #1;
    chk("arst_PC",       PC,                      32'h0);
    chk("arst_ReqValid", {31'h0, Inst_Req_Valid}, 32'h0);
    chk("arst_InstReady",{31'h0, Inst_Ready},     32'h0);
    chk("arst_Done",     {31'h0, Done_O},         32'h0);
    chk("arst_PC_O",     PC_O,                    32'h0);
    chk("arst_Inst",     Inst,                    32'h0000_0013);
    $display("async reset: PC=%08h done=%0b PC_O=%08h Inst=%08h", PC, Done_O, PC_O, Inst);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_delay = 1;

    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      #1;
      if (Inst_Req_Valid) begin
        seen = 1'b1;
        chk("post_rst_req_PC", PC, 32'h0);
        $display("post-reset request: PC=%08h", PC);
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) chk("post_rst_req_timeout", 32'h0, 32'h1);

    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (Done_O) begin
        seen = 1'b1;
        chk("post_rst_PC_O", PC_O, 32'h0);
        chk("post_rst_Inst", Inst, 32'h0010_0093);
        $display("post-reset done: PC_O=%08h Inst=%08h", PC_O, Inst);
      end
    end
    if (!seen) chk("post_rst_done_timeout", 32'h0, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
